// File: rtl/car_motion_if.sv
// Handshake bundle between the goal selector / lamp panel and the car_motion block.
interface car_motion_if;
   logic [1:0] gf;
   logic       led1, led2, led3;
   logic [1:0] floor;
   logic       move_handler, up, down, door_open;
   logic       clr1, clr2, clr3;

   modport master (output gf, led1, led2, led3,
                   input  floor, move_handler, up, down, door_open, clr1, clr2, clr3);
   modport slave  (input  gf, led1, led2, led3,
                   output floor, move_handler, up, down, door_open, clr1, clr2, clr3);
endinterface

// File: rtl/car_motion.sv
// Elevator car motion controller: IDLE/MOVE/DOOR sequencing with a shared 16-bit down-counter.
// Optional door obstruction input is enabled by defining DOOR_OBSTRUCT_EN.
module car_motion #(
   parameter int         TRAVEL_CYCLES = 4,
   parameter int         DOOR_CYCLES   = 3,
   parameter logic [1:0] labelF1       = 2'b00,
   parameter logic [1:0] labelF2       = 2'b01,
   parameter logic [1:0] labelF3       = 2'b10
) (
   input logic          clk,
   input logic          rst_n,
`ifdef DOOR_OBSTRUCT_EN
   input logic          obstruct,
`endif
   car_motion_if.slave  bus
);
   localparam logic [15:0] TRAVEL_RLD = 16'(TRAVEL_CYCLES - 1);
   localparam logic [15:0] DOOR_RLD   = 16'(DOOR_CYCLES - 1);

   typedef enum logic [1:0] {IDLE, MOVE, DOOR} state_t;

   state_t      state, state_n;
   logic [15:0] timer, timer_n;
   logic [1:0]  floor_q, floor_n, target, target_n, step_f;
   logic        up_q, up_n, down_q, down_n, door_q, door_n, mh_q, mh_n;
   logic [2:0]  clr_q, clr_n;
   logic        lamp_q, cur_lamp, valid_gf;

   function automatic logic [2:0] onehot(input logic [1:0] f);
      return {f == labelF3, f == labelF2, f == labelF1};
   endfunction

   assign cur_lamp = |({bus.led3, bus.led2, bus.led1} & onehot(floor_q));
   assign valid_gf = (bus.gf == labelF1) || (bus.gf == labelF2) || (bus.gf == labelF3);
   // neighbour label in the travel direction; saturates at the end floors
   assign step_f   = up_q ? ((floor_q == labelF1) ? labelF2 : labelF3)
                          : ((floor_q == labelF3) ? labelF2 : labelF1);

   always_comb begin
      state_n  = state;
      timer_n  = timer;
      floor_n  = floor_q;
      target_n = target;
      up_n     = up_q;
      down_n   = down_q;
      door_n   = door_q;
      mh_n     = mh_q;
      clr_n    = '0;
      case (state)
         IDLE: begin
            if (cur_lamp) begin
               state_n = DOOR;
               timer_n = DOOR_RLD;
               door_n  = 1'b1;
               mh_n    = 1'b1;
               clr_n   = onehot(floor_q);
            end else if (valid_gf && bus.gf != floor_q) begin
               state_n  = MOVE;
               timer_n  = TRAVEL_RLD;
               target_n = bus.gf;
               up_n     = bus.gf > floor_q;
               down_n   = bus.gf < floor_q;
               mh_n     = 1'b1;
            end
         end
         MOVE: begin
            if (timer == 16'd0) begin
               floor_n = step_f;
               if (step_f == target) begin
                  state_n = DOOR;
                  timer_n = DOOR_RLD;
                  door_n  = 1'b1;
                  up_n    = 1'b0;
                  down_n  = 1'b0;
                  clr_n   = onehot(step_f);
               end else begin
                  timer_n = TRAVEL_RLD;
               end
            end else begin
               timer_n = timer - 16'd1;
            end
         end
         DOOR: begin
`ifdef DOOR_OBSTRUCT_EN
            if (obstruct) timer_n = DOOR_RLD;
            else
`endif
            if (timer == 16'd0) begin
               state_n = IDLE;
               door_n  = 1'b0;
               mh_n    = 1'b0;
            end else begin
               timer_n = timer - 16'd1;
            end
            // a lamp re-raised while the door is open gets one extra clear, no extension
            if (cur_lamp && !lamp_q && state_n == DOOR) clr_n = onehot(floor_q);
         end
         default: state_n = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state   <= IDLE;
         timer   <= '0;
         floor_q <= labelF1;
         target  <= labelF1;
         up_q    <= 1'b0;
         down_q  <= 1'b0;
         door_q  <= 1'b0;
         mh_q    <= 1'b0;
         clr_q   <= '0;
         lamp_q  <= 1'b0;
      end else begin
         state   <= state_n;
         timer   <= timer_n;
         floor_q <= floor_n;
         target  <= target_n;
         up_q    <= up_n;
         down_q  <= down_n;
         door_q  <= door_n;
         mh_q    <= mh_n;
         clr_q   <= clr_n;
         lamp_q  <= cur_lamp;
      end
   end

   assign bus.floor        = floor_q;
   assign bus.up           = up_q;
   assign bus.down         = down_q;
   assign bus.door_open    = door_q;
   assign bus.move_handler = mh_q;
   assign bus.clr1         = clr_q[0];
   assign bus.clr2         = clr_q[1];
   assign bus.clr3         = clr_q[2];
endmodule

// File: tb/tb_car_motion.sv
// Directed bench for car_motion at TRAVEL_CYCLES=4, DOOR_CYCLES=3.
module tb_car_motion;
   logic clk = 1'b0;
   logic rst_n;
`ifdef DOOR_OBSTRUCT_EN
   logic obstruct = 1'b0;
`endif
   int checks = 0;
   int errors = 0;
   int nu, nd, ndw, nc, bad;

   car_motion_if bus ();

   car_motion #(.TRAVEL_CYCLES(4), .DOOR_CYCLES(3)) dut (
      .clk      (clk),
      .rst_n    (rst_n),
`ifdef DOOR_OBSTRUCT_EN
      .obstruct (obstruct),
`endif
      .bus      (bus)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got %0h exp %0h", tag, got, exp);
      end
   endtask

   function automatic logic [7:0] outs();
      return {bus.up, bus.down, bus.door_open, bus.move_handler, bus.clr1, bus.clr2, bus.clr3, 1'b0};
   endfunction

   initial begin
      rst_n = 1'b0; bus.gf = 2'b11; bus.led1 = 0; bus.led2 = 0; bus.led3 = 0;
      repeat (2) @(negedge clk);
      chk("rst_floor", 32'(bus.floor), 0);
      chk("rst_outs", 32'(outs()), 0);
      rst_n = 1'b1;
      @(negedge clk);

      // F1 -> F3
      bus.gf = 2'b10; nu = 0; nd = 0; ndw = 0; nc = 0;
      for (int i = 1; i <= 12; i++) begin
         @(negedge clk);
         nu += int'(bus.up); nd += int'(bus.down); ndw += int'(bus.door_open); nc += int'(bus.clr3);
         if (i == 1)  chk("s1_mh_on", 32'(bus.move_handler), 1);
         if (i == 4)  chk("s1_latency", 32'(bus.floor), 0);
         if (i == 5)  chk("s1_step1", 32'(bus.floor), 1);
         if (i == 9)  chk("s1_arrive", 32'(bus.floor), 2);
         if (i == 11) chk("s1_mh_door", 32'(bus.move_handler), 1);
         if (i == 12) chk("s1_mh_idle", 32'(bus.move_handler), 0);
      end
      chk("s1_up_cnt", 32'(nu), 8);
      chk("s1_down_cnt", 32'(nd), 0);
      chk("s1_door_cnt", 32'(ndw), 3);
      chk("s1_clr3_cnt", 32'(nc), 1);

      // F3 -> F2
      bus.gf = 2'b01; nd = 0; ndw = 0;
      for (int i = 1; i <= 12; i++) begin
         @(negedge clk);
         nd += int'(bus.down); ndw += int'(bus.door_open);
      end
      chk("s2_floor", 32'(bus.floor), 1);
      chk("s2_down_cnt", 32'(nd), 4);
      chk("s2_door_cnt", 32'(ndw), 3);

      // lamp at current floor, re-raised mid-door
      bus.gf = 2'b11; bus.led2 = 1;
      @(negedge clk);
      chk("s3_door", 32'(bus.door_open), 1);
      chk("s3_clr2", 32'(bus.clr2), 1);
      chk("s3_updown", 32'({bus.up, bus.down}), 0);
      bus.led2 = 0;
      @(negedge clk);
      chk("s3_clr2_off", 32'(bus.clr2), 0);
      bus.led2 = 1;
      @(negedge clk);
      chk("s3_reclr2", 32'(bus.clr2), 1);
      chk("s3_door_last", 32'(bus.door_open), 1);
      bus.led2 = 0;
      @(negedge clk);
      chk("s3_no_extend", 32'(bus.door_open), 0);
      chk("s3_mh_idle", 32'(bus.move_handler), 0);

      // F2 -> F1, then F1 -> F3 with gf changed mid-move
      bus.gf = 2'b00;
      repeat (12) @(negedge clk);
      chk("s4_at_f1", 32'(bus.floor), 0);
      bus.gf = 2'b10; ndw = 0; bad = 0;
      for (int i = 1; i <= 14; i++) begin
         @(negedge clk);
         if (i == 2)  bus.gf = 2'b01;
         if (i == 10) bus.gf = 2'b11;
         ndw += int'(bus.door_open);
         if (bus.door_open && bus.floor == 2'b01) bad++;
         if (i == 9) chk("s4_arrive", 32'(bus.floor), 2);
      end
      chk("s4_no_f2_stop", 32'(bad), 0);
      chk("s4_door_cnt", 32'(ndw), 3);

      // async reset mid-move at F2
      bus.gf = 2'b00;
      repeat (6) @(negedge clk);
      chk("s5_pre_floor", 32'(bus.floor), 1);
      chk("s5_pre_down", 32'(bus.down), 1);
      rst_n = 1'b0;
      #1;
      chk("s5_rst_floor", 32'(bus.floor), 0);
      chk("s5_rst_outs", 32'(outs()), 0);
      bus.gf = 2'b11;
      @(negedge clk);
      chk("s5_hold_outs", 32'(outs()), 0);
      rst_n = 1'b1;

      // invalid goal held in IDLE
      bad = 0;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         if (bus.floor != 2'b00 || bus.up || bus.down || bus.move_handler) bad++;
      end
      chk("s6_gf11_idle", 32'(bad), 0);

      // resume from F1
      bus.gf = 2'b01;
      for (int i = 1; i <= 8; i++) begin
         @(negedge clk);
         if (i == 1) bus.gf = 2'b11;
         if (i == 4) chk("s7_latency", 32'(bus.floor), 0);
         if (i == 5) chk("s7_step", 32'(bus.floor), 1);
      end
      chk("s7_idle", 32'(bus.move_handler), 0);

`ifdef DOOR_OBSTRUCT_EN
      bus.led2 = 1; ndw = 0;
      for (int i = 1; i <= 10; i++) begin
         @(negedge clk);
         ndw += int'(bus.door_open);
         if (i == 1) begin bus.led2 = 0; obstruct = 1; end
         if (i == 6) obstruct = 0;
      end
      chk("s8_obstruct_door", 32'(ndw), 8);
`endif

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule

// File: doc/car_motion.md
CAR_MOTION -- requirements
Module: car_motion

Interface
REQ-001 Parameter: TRAVEL_CYCLES, default 4, clock cycles per one-floor move (minimum 1, maximum 65535).
REQ-002 Parameter: DOOR_CYCLES, default 3, clock cycles the door stays open (minimum 1, maximum 65535).
REQ-003 Parameter: labelF1 / labelF2 / labelF3, defaults 2'b00 / 2'b01 / 2'b10, floor encodings.
REQ-004 Clocking and reset: one clock; reset is asynchronous and active-low.
REQ-005 clk  input  1  rising-edge system clock.
REQ-006 rst_n  input  1  asynchronous active-low reset.
REQ-007 gf  input  2  goal floor from the goal selector; sampled only in IDLE.
REQ-008 led1, led2, led3  input  1 each  pending-request lamps for F1, F2, F3.
REQ-009 floor  output  2  current car floor, registered.
REQ-010 move_handler  output  1  high while the car is busy (MOVE or DOOR); tells the goal selector to freeze gf.
REQ-011 up, down  output  1 each  direction of travel; high only in MOVE.
REQ-012 door_open  output  1  high throughout DOOR.
REQ-013 clr1, clr2, clr3  output  1 each  one-cycle pulse that clears the lamp of the floor being served.
REQ-014 obstruct  input  1  door obstruction sensor; present only with DOOR_OBSTRUCT_EN.

Function
REQ-015 FSM states SHALL be IDLE, MOVE and DOOR, using a 16-bit down-counter named timer.
REQ-016 IDLE -> DOOR when the lamp for the current floor is high; this check takes priority over gf.
REQ-017 IDLE -> MOVE when gf is a valid label and gf != floor; on that edge, timer = TRAVEL_CYCLES-1 and up/down are set.
REQ-018 up is set when gf > floor; down is set when gf < floor.
REQ-019 gf = 2'b11, or gf == floor with no lamp for that floor, SHALL keep the block in IDLE.
REQ-020 MOVE: timer decrements each cycle.
REQ-021 MOVE, timer == 0: floor steps by ±1 toward the latched target.
REQ-022 After the step, if the new floor equals the target: go to DOOR. Otherwise reload timer = TRAVEL_CYCLES-1 and stay in MOVE.
REQ-023 The target SHALL be latched on IDLE->MOVE; gf changes during MOVE are ignored.
REQ-024 floor SHALL never leave the range labelF1..labelF3; no wrap-around is permitted.
REQ-025 DOOR entry edge: timer = DOOR_CYCLES-1, door_open = 1, and clrN pulses for exactly one cycle for N = floor.
REQ-026 DOOR: timer decrements each cycle; at timer == 0 the FSM returns to IDLE and door_open drops.
REQ-027 move_handler SHALL be registered and high in every MOVE and DOOR cycle; it is low in IDLE.
REQ-028 A lamp for the current floor that rises during DOOR SHALL be cleared by an extra clrN pulse on the following cycle.
REQ-029 Such a re-raised lamp SHALL NOT extend the door.
REQ-030 Latency: the first floor change occurs TRAVEL_CYCLES+1 edges after gf is sampled in IDLE.

Reset
REQ-031 While rst_n is low: state = IDLE, floor = labelF1, timer = 0.
REQ-032 While rst_n is low: up, down, door_open, move_handler and clr1..3 are all 0.
REQ-033 Reset mid-MOVE or mid-DOOR SHALL abort immediately with no clr pulse.
REQ-034 After rst_n deasserts, operation SHALL resume from IDLE at labelF1.

Configuration
REQ-035 Macro DOOR_OBSTRUCT_EN defined: port obstruct exists.
REQ-036 With DOOR_OBSTRUCT_EN, obstruct high in DOOR reloads timer = DOOR_CYCLES-1 every cycle it is high.
REQ-037 With DOOR_OBSTRUCT_EN, the door closes DOOR_CYCLES cycles after obstruct falls.
REQ-038 Macro undefined: no obstruct port, and the door stays open exactly DOOR_CYCLES cycles.

Verification (TRAVEL_CYCLES=4, DOOR_CYCLES=3)
REQ-039 Reset at floor F1, gf=10: up=1 for 8 cycles.
REQ-040 In the same scenario, floor goes 00 -> 01 -> 10, then door_open=1 for 3 cycles with clr3 pulsing once, then IDLE with move_handler=0.
REQ-041 Idle at F2 with led2=1: DOOR within 1 cycle, clr2 pulses, no up/down, door closes after 3 cycles.
REQ-042 Start F1->F3; gf changes to 01 mid-move: the car still stops only at 10.
REQ-043 gf=11 held for 20 cycles in IDLE: floor, up, down and move_handler all stay 0.
REQ-044 rst_n pulsed low during MOVE at floor 01: all outputs go to 0 asynchronously and floor = 00.
REQ-045 With DOOR_OBSTRUCT_EN, obstruct held high 5 cycles in DOOR: door_open lasts 5+3 cycles.
